// File: rtl/sd_host_sched.sv
// rtl/sd_host_sched.sv - SPI-mode SD host scheduler: power-up, init retry, request dispatch, card line mux
module sd_host_sched #(
  parameter int PWRUP_CYC  = 80,
  parameter int INIT_RETRY = 3,
  parameter int TIMEOUT    = 500000
) (
  input  logic        SD_CLK,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  output logic        req_ack,
  output logic        ready,
  output logic        done,
  output logic        status,
  output logic        fail,
  output logic        init_start,
  input  logic        init_o,
  input  logic        init_fail,
  output logic        rd_start,
  output logic        wr_start,
  output logic [31:0] op_addr,
  input  logic        rd_done,
  input  logic        rd_err,
  input  logic        wr_done,
  input  logic        wr_err,
  input  logic        init_cs,
  input  logic        init_mosi,
  input  logic        rd_cs,
  input  logic        rd_mosi,
  input  logic        wr_cs,
  input  logic        wr_mosi,
  output logic        sd_cs,
  output logic        sd_mosi
);

  typedef enum logic [2:0] {S_PWRUP, S_INIT, S_IDLE, S_READ, S_WRITE, S_FAIL} state_t;

  localparam logic [23:0] PWRUP_LOAD = 24'(PWRUP_CYC - 1);
  localparam logic [23:0] TMO_LAST   = 24'(TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX  = 4'(INIT_RETRY);

  state_t      state, state_d;
  logic [23:0] tcnt, tcnt_d;
  logic [3:0]  retry, retry_d;
  logic        last, last_d;
  logic [31:0] op_addr_d;
  logic        req_ack_d, done_d, status_d, init_start_d, rd_start_d, wr_start_d;
  logic        eng_done, eng_err, grant_rd;

  assign eng_done = (state == S_WRITE) ? wr_done : rd_done;
  assign eng_err  = (state == S_WRITE) ? wr_err  : rd_err;
  // last = 1 means the previous grant was a write, so read wins the next tie
  assign grant_rd = rd_req && (!wr_req || last);

  always_ff @(posedge SD_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PWRUP;
      tcnt       <= PWRUP_LOAD;
      retry      <= '0;
      last       <= 1'b1;
      op_addr    <= '0;
      req_ack    <= 1'b0;
      done       <= 1'b0;
      status     <= 1'b0;
      init_start <= 1'b0;
      rd_start   <= 1'b0;
      wr_start   <= 1'b0;
    end else begin
      state      <= state_d;
      tcnt       <= tcnt_d;
      retry      <= retry_d;
      last       <= last_d;
      op_addr    <= op_addr_d;
      req_ack    <= req_ack_d;
      done       <= done_d;
      status     <= status_d;
      init_start <= init_start_d;
      rd_start   <= rd_start_d;
      wr_start   <= wr_start_d;
    end
  end

  always_comb begin
    state_d      = state;
    tcnt_d       = tcnt;
    retry_d      = retry;
    last_d       = last;
    op_addr_d    = op_addr;
    req_ack_d    = 1'b0;
    done_d       = 1'b0;
    status_d     = 1'b0;
    init_start_d = 1'b0;
    rd_start_d   = 1'b0;
    wr_start_d   = 1'b0;
    case (state)
      S_PWRUP: begin
        if (tcnt == '0) begin
          state_d      = S_INIT;
          init_start_d = 1'b1;
          tcnt_d       = '0;
        end else begin
          tcnt_d = tcnt - 24'd1;
        end
      end
      S_INIT: begin
        if (init_o) begin
          state_d = S_IDLE;
        end else if (init_fail || tcnt == TMO_LAST) begin
          retry_d = retry + 4'd1;
          if (retry_d < RETRY_MAX) begin
            state_d = S_PWRUP;
            tcnt_d  = PWRUP_LOAD;
          end else begin
            state_d = S_FAIL;
          end
        end else begin
          tcnt_d = tcnt + 24'd1;
        end
      end
      S_IDLE: begin
        if (rd_req || wr_req) begin
          op_addr_d = addr;
          req_ack_d = 1'b1;
          tcnt_d    = '0;
          last_d    = !grant_rd;
          if (grant_rd) begin
            state_d    = S_READ;
            rd_start_d = 1'b1;
          end else begin
            state_d    = S_WRITE;
            wr_start_d = 1'b1;
          end
        end
      end
      S_READ, S_WRITE: begin
        // an engine pulse on the timeout edge still reports its own outcome
        if (eng_err || eng_done) begin
          done_d   = 1'b1;
          status_d = eng_err;
          state_d  = S_IDLE;
        end else if (tcnt == TMO_LAST) begin
          done_d   = 1'b1;
          status_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tcnt_d = tcnt + 24'd1;
        end
      end
      S_FAIL: ;
      default: state_d = S_PWRUP;
    endcase
  end

  assign ready = (state == S_IDLE);
  assign fail  = (state == S_FAIL);

  always_comb begin
    sd_cs   = 1'b1;
    sd_mosi = 1'b1;
    case (state)
      S_INIT:  begin sd_cs = init_cs; sd_mosi = init_mosi; end
      S_READ:  begin sd_cs = rd_cs;   sd_mosi = rd_mosi;   end
      S_WRITE: begin sd_cs = wr_cs;   sd_mosi = wr_mosi;   end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sd_host_sched.sv
// tb/tb_sd_host_sched.sv - randomized self-checking bench for sd_host_sched
module tb_sd_host_sched;

  localparam int PWRUP_CYC  = 80;
  localparam int INIT_RETRY = 3;
  localparam int TIMEOUT    = 1000;

  logic        SD_CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req = 1'b0, wr_req = 1'b0;
  logic [31:0] addr = '0;
  logic        req_ack, ready, done, status, fail, init_start;
  logic        init_o = 1'b0, init_fail = 1'b0;
  logic        rd_start, wr_start;
  logic [31:0] op_addr;
  logic        rd_done = 1'b0, rd_err = 1'b0, wr_done = 1'b0, wr_err = 1'b0;
  logic        init_cs = 1'b0, init_mosi = 1'b0;
  logic        rd_cs = 1'b0, rd_mosi = 1'b0, wr_cs = 1'b0, wr_mosi = 1'b0;
  logic        sd_cs, sd_mosi;

  int total = 0;
  int bad   = 0;
  int tries;
  bit prev_wr;

  always #5 SD_CLK = ~SD_CLK;

  sd_host_sched #(.PWRUP_CYC(PWRUP_CYC), .INIT_RETRY(INIT_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .SD_CLK(SD_CLK), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .req_ack(req_ack), .ready(ready), .done(done), .status(status), .fail(fail),
    .init_start(init_start), .init_o(init_o), .init_fail(init_fail),
    .rd_start(rd_start), .wr_start(wr_start), .op_addr(op_addr),
    .rd_done(rd_done), .rd_err(rd_err), .wr_done(wr_done), .wr_err(wr_err),
    .init_cs(init_cs), .init_mosi(init_mosi), .rd_cs(rd_cs), .rd_mosi(rd_mosi),
    .wr_cs(wr_cs), .wr_mosi(wr_mosi), .sd_cs(sd_cs), .sd_mosi(sd_mosi)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SD_CLK);
    #1;
  endtask

  task automatic clear_pulses();
    init_o = 1'b0; init_fail = 1'b0;
    rd_done = 1'b0; rd_err = 1'b0; wr_done = 1'b0; wr_err = 1'b0;
  endtask

  // kind: 0 init_o, 1 init_fail, 2 both, 3 none (attempt times out, d = TIMEOUT)
  task automatic run_attempt(input int d, input int kind);
    int k;
    k = -1;
    for (int i = 1; i <= 3 * PWRUP_CYC; i++) begin
      check("pwrup_lines", {sd_cs, sd_mosi}, 2'b11);
      check("pwrup_ready", ready, 1'b0);
      tick();
      if (init_start) begin k = i; break; end
    end
    check("init_start_lat", k, PWRUP_CYC);
    if (k < 0) return;
    tries++;
    for (int c = 1; c <= d; c++) begin
      init_cs = 1'($urandom); init_mosi = 1'($urandom);
      rd_done = ($urandom_range(0, 7) == 0); wr_err = ($urandom_range(0, 7) == 0);
      if (c == d && kind != 3) begin
        init_o    = (kind == 0 || kind == 2);
        init_fail = (kind == 1 || kind == 2);
      end
      #1;
      check("init_mux", {sd_cs, sd_mosi}, {init_cs, init_mosi});
      check("init_ready", ready, 1'b0);
      tick();
      clear_pulses();
    end
    if (kind == 0 || kind == 2) begin
      check("init_ok_ready", ready, 1'b1);
      check("init_ok_fail", fail, 1'b0);
    end else begin
      check("init_bad_ready", ready, 1'b0);
      check("init_bad_fail", fail, (tries >= INIT_RETRY));
    end
  endtask

  // resp: 0 done, 1 err, 2 done+err, 3 none (timeout)
  task automatic run_op(input bit rq, input bit wq, input logic [31:0] a, input int resp, input int d);
    bit exp_wr;
    int exp_cnt, got, gap;
    exp_wr  = (rq && wq) ? !prev_wr : wq;
    prev_wr = exp_wr;
    exp_cnt = (resp == 3) ? TIMEOUT : d;
    rd_req = rq; wr_req = wq; addr = a;
    tick();
    check("grant_ack", req_ack, 1'b1);
    check("grant_start", {rd_start, wr_start}, {!exp_wr, exp_wr});
    check("grant_addr", op_addr, a);
    check("grant_ready", ready, 1'b0);
    check("grant_done", done, 1'b0);
    rd_req = 1'b0; wr_req = 1'b0; addr = $urandom;
    got = -1;
    for (int c = 1; c <= TIMEOUT + 20; c++) begin
      rd_cs = 1'($urandom); rd_mosi = 1'($urandom); wr_cs = 1'($urandom); wr_mosi = 1'($urandom);
      init_o = ($urandom_range(0, 7) == 0); init_fail = ($urandom_range(0, 7) == 0);
      if (exp_wr) begin
        rd_done = ($urandom_range(0, 7) == 0); rd_err = ($urandom_range(0, 7) == 0);
      end else begin
        wr_done = ($urandom_range(0, 7) == 0); wr_err = ($urandom_range(0, 7) == 0);
      end
      if (resp != 3 && c == d) begin
        if (exp_wr) begin wr_done = (resp != 1); wr_err = (resp != 0); end
        else        begin rd_done = (resp != 1); rd_err = (resp != 0); end
      end
      #1;
      check("op_mux", {sd_cs, sd_mosi}, exp_wr ? {wr_cs, wr_mosi} : {rd_cs, rd_mosi});
      tick();
      clear_pulses();
      if (done) begin got = c; break; end
      check("op_quiet", {req_ack, rd_start, wr_start, ready}, 4'b0);
    end
    check("op_latency", got, exp_cnt);
    check("op_status", status, (resp != 0));
    check("op_ready", ready, 1'b1);
    check("op_idle_lines", {sd_cs, sd_mosi}, 2'b11);
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      rd_done = 1'($urandom); wr_err = 1'($urandom); init_fail = 1'($urandom);
      tick();
      clear_pulses();
      check("gap_done", done, 1'b0);
      check("gap_ready", ready, 1'b1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int p;
    tick();
    tick();
    check("rst_outs", {req_ack, ready, done, status, fail, init_start, rd_start, wr_start}, 8'h00);
    check("rst_addr", op_addr, 32'h0);
    check("rst_lines", {sd_cs, sd_mosi}, 2'b11);

    rst_n = 1'b1; tries = 0; prev_wr = 1'b1;
    run_attempt(20, 0);

    for (int i = 0; i < 4; i++) run_op(1'b1, 1'b1, $urandom, 0, $urandom_range(1, 30));
    run_op(1'b1, 1'b0, 32'h0000_1234, 0, 300);
    run_op(1'b0, 1'b1, $urandom, 3, 0);
    run_op(1'b1, 1'b0, $urandom, 0, TIMEOUT);
    run_op(1'b0, 1'b1, $urandom, 2, 5);
    run_op(1'b1, 1'b0, $urandom, 1, 1);
    for (int i = 0; i < 25; i++) begin
      p = $urandom_range(1, 3);
      run_op(p[0], p[1], $urandom, ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2),
             $urandom_range(1, 40));
    end

    rd_req = 1'b1; addr = $urandom;
    tick();
    check("midrst_ack", {req_ack, rd_start}, 2'b11);
    rd_req = 1'b0; rd_cs = 1'b0; rd_mosi = 1'b0;
    repeat (10) tick();
    check("midrst_owned", {sd_cs, sd_mosi}, 2'b00);
    rst_n = 1'b0;
    #1;
    check("midrst_lines", {sd_cs, sd_mosi}, 2'b11);
    check("midrst_outs", {req_ack, ready, done, fail, rd_start}, 5'b0);
    check("midrst_addr", op_addr, 32'h0);
    tick();
    rst_n = 1'b1; tries = 0; prev_wr = 1'b1;
    run_attempt(20, 2);
    run_op(1'b1, 1'b1, $urandom, 0, 3);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; tries = 0; prev_wr = 1'b1;
    run_attempt(5, 1);
    run_attempt(TIMEOUT, 3);
    run_attempt(7, 1);
    rd_req = 1'b1; wr_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rd_done = 1'($urandom); init_o = 1'($urandom);
      tick();
      clear_pulses();
      check("fail_hold", {req_ack, rd_start, wr_start, ready, fail, sd_cs, sd_mosi}, 7'b0000111);
    end
    rd_req = 1'b0; wr_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_host_sched.md
# sd_host_sched

Top-level scheduler for the SD host in SPI mode. After power-up it runs the card power-up clocks and starts the initialisation engine, retrying a bounded number of times. Once the card is ready, it accepts block read/write requests from the user side and dispatches each one to the read or write engine. It arbitrates the shared card lines (CS, host-to-card data) between the init, read and write engines, so exactly one engine drives the card at any time.

## Interface
- PWRUP_CYC, 80: SD_CLK cycles with CS and data high before each init attempt (card needs ≥74).
- INIT_RETRY, 3: total init attempts before permanent failure (1..15).
- TIMEOUT, 500000: max cycles per init attempt or per block operation; counter is 24 bits.
- SD_CLK  in  1  clock; all registers update on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- rd_req / wr_req  in  1  user request levels, held until req_ack.
- addr  in  32  block address, sampled on grant.
- req_ack  out  1  one-cycle grant pulse.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle completion pulse.
- status  out  1  valid with done: 0 = ok, 1 = error or timeout.
- fail  out  1  sticky init failure; cleared only by reset.
- init_start  out  1  one-cycle start pulse to the init engine.
- init_o / init_fail  in  1  init engine done / failed.
- rd_start, wr_start  out  1  one-cycle start pulses.
- op_addr  out  32  latched address for read/write engines.
- rd_done, rd_err, wr_done, wr_err  in  1  engine completion pulses.
- init_cs, init_mosi, rd_cs, rd_mosi, wr_cs, wr_mosi  in  1  engine-driven card lines.
- sd_cs, sd_mosi  out  1  muxed lines to the card.

## Operation
- States: PWRUP, INIT, IDLE, READ, WRITE, FAIL. Register `retry` is 4 bits; register `last` is the last grant (0 = read, 1 = write); `tcnt` is the timeout counter.
- **PWRUP**
  - Load tcnt = PWRUP_CYC−1 and count down.
  - At 0: go to INIT, pulse init_start, clear tcnt.
- **INIT**
  - init_o goes to IDLE.
  - init_fail, or tcnt reaching TIMEOUT−1: retry += 1.
  - After the increment, if retry < INIT_RETRY, go to PWRUP; otherwise go to FAIL.
- **IDLE**
  - ready = 1.
  - Only one of rd_req / wr_req high: grant that one.
  - Both high: grant the opposite of `last` (round robin).
  - On grant:
    - latch op_addr = addr;
    - pulse req_ack;
    - pulse rd_start or wr_start in the cycle after the grant edge;
    - go to READ or WRITE; update `last`; clear tcnt.
- **READ / WRITE**
  - Engine done: pulse done with status = 0, then go to IDLE.
  - Engine err: pulse done with status = 1, then go to IDLE.
  - tcnt reaching TIMEOUT−1: pulse done with status = 1, then go to IDLE.
- **FAIL**
  - fail = 1, ready = 0; requests are never acked. Exit only by reset.
- **Line mux**
  - INIT → init_cs/init_mosi; READ → rd_*; WRITE → wr_*.
  - PWRUP, IDLE, FAIL → sd_cs = 1, sd_mosi = 1.
  - The select is registered state, and the mux is combinational.
- Engine inputs that do not belong to the current state are ignored; for example, rd_done in IDLE or init_fail in READ has no effect.

## Timing
- **Reset values:** state = PWRUP, tcnt = PWRUP_CYC−1, retry = 0, last = 1 (read wins the first tie).
- **Outputs in reset:** req_ack, ready, done, status, fail, init_start, rd_start and wr_start = 0; op_addr = 0; sd_cs = 1, sd_mosi = 1.
- init_start rises PWRUP_CYC cycles after reset release.
- **Grant latency:**
  - req_ack is high in cycle N+1 for a request sampled in IDLE at edge N.
  - rd_start / wr_start is high in cycle N+1 as well.
  - The engine owns the lines from cycle N+1.
- done is high exactly one cycle after the sampled engine pulse, and ready returns in the same cycle as done.
- A back-to-back request can be granted at the edge after done, so there is 1 idle cycle minimum between operations.
- **Simultaneous events:**
  - done and err together: err wins, status = 1.
  - done and timeout together: done wins, status = 0.
  - init_o and init_fail together: init_o wins.
- Reset mid-operation returns immediately to PWRUP with reset values. An engine in progress sees its lines released (CS high).

## Test plan
- **Power-up and init:** release reset with init_o pulsed 20 cycles after init_start → init_start at cycle 80; sd_cs = 1 throughout PWRUP; ready = 1 the cycle after init_o.
- **Init retry and fail:** init_fail on every attempt, INIT_RETRY = 3 → three init_start pulses, each preceded by 80 CS-high cycles; then fail = 1 and ready = 0; rd_req is never acked.
- **Read:** read of addr 0x0000_1234, rd_done after 300 cycles → req_ack and rd_start the next cycle; op_addr = 0x1234; sd_cs follows rd_cs; done = 1 with status = 0.
- **Tie:** rd_req and wr_req held together → grants alternate read, write, read, write across 4 operations.
- **Timeout:** write with no wr_done, TIMEOUT = 1000 → done with status = 1 at 1000 cycles after grant; then IDLE.
- **Mid-op reset:** rst_n low during READ → sd_cs = 1 and state PWRUP; init_start again 80 cycles after release.
